// File: rtl/arrival_timestamper.sv
// Per-port ingress stage: stamps each packet with its arrival time and passes it on
// through a registered 2-entry skid buffer.
module arrival_timestamper #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_TS_WIDTH           = 32,
  parameter int C_TS_POS             = 32
) (
  input  logic                              axi_aclk,
  input  logic                              reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic                              stamp_en,
  input  logic                              ts_clear,
  output logic [C_TS_WIDTH-1:0]             ts_now,
  output logic [31:0]                       pkt_cnt
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam logic [C_TS_WIDTH-1:0] TS_ONE = {{(C_TS_WIDTH-1){1'b0}}, 1'b1};

  logic [C_TS_WIDTH-1:0] ts_cnt_r;
  logic [C_TS_WIDTH-1:0] cur_ts_r;
  logic [C_TS_WIDTH-1:0] stamp_s;
  logic [31:0]           pkt_cnt_r;
  logic                  sop_r;
  logic                  tready_r;
  logic                  accept_s;
  logic                  out_free_s;
  logic                  skid_next_s;
  logic [UW-1:0]         in_user_s;

  logic          skid_valid_r;
  logic [DW-1:0] skid_data_r;
  logic [SW-1:0] skid_strb_r;
  logic [UW-1:0] skid_user_r;
  logic          skid_last_r;

  logic          out_valid_r;
  logic [DW-1:0] out_data_r;
  logic [SW-1:0] out_strb_r;
  logic [UW-1:0] out_user_r;
  logic          out_last_r;

  function automatic logic [UW-1:0] insert_stamp(input logic [UW-1:0]         user,
                                                 input logic [C_TS_WIDTH-1:0] stamp);
    logic [UW-1:0] res;
    res = user;
    res[C_TS_POS +: C_TS_WIDTH] = stamp;
    return res;
  endfunction

  // Handshake decode, stamp selection and skid occupancy for the next cycle
  always_comb begin
    accept_s    = s_axis_tvalid && tready_r;
    out_free_s  = !out_valid_r || m_axis_tready;
    // The SOP beat bypasses cur_ts so every beat of a packet carries the same value
    if (sop_r) begin
      stamp_s = ts_cnt_r;
    end else begin
      stamp_s = cur_ts_r;
    end
    if (stamp_en) begin
      in_user_s = insert_stamp(s_axis_tuser, stamp_s);
    end else begin
      in_user_s = s_axis_tuser;
    end
    skid_next_s = skid_valid_r;
    if (out_free_s) begin
      skid_next_s = 1'b0;
    end else if (accept_s) begin
      skid_next_s = 1'b1;
    end else begin
      skid_next_s = skid_valid_r;
    end
  end

  // Arrival counter, packet tracking and ingress ready
  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      ts_cnt_r  <= {C_TS_WIDTH{1'b0}};
      cur_ts_r  <= {C_TS_WIDTH{1'b0}};
      pkt_cnt_r <= 32'd0;
      sop_r     <= 1'b1;
      tready_r  <= 1'b0;
    end else begin
      if (ts_clear) begin
        ts_cnt_r <= {C_TS_WIDTH{1'b0}};
      end else begin
        ts_cnt_r <= ts_cnt_r + TS_ONE;
      end
      tready_r <= !skid_next_s;
      if (accept_s) begin
        sop_r <= s_axis_tlast;
        if (sop_r) begin
          cur_ts_r <= ts_cnt_r;
        end
        if (s_axis_tlast) begin
          pkt_cnt_r <= pkt_cnt_r + 32'd1;
        end
      end
    end
  end

  // Output register and skid register datapath
  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      skid_valid_r <= 1'b0;
      skid_data_r  <= {DW{1'b0}};
      skid_strb_r  <= {SW{1'b0}};
      skid_user_r  <= {UW{1'b0}};
      skid_last_r  <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= {DW{1'b0}};
      out_strb_r   <= {SW{1'b0}};
      out_user_r   <= {UW{1'b0}};
      out_last_r   <= 1'b0;
    end else begin
      skid_valid_r <= skid_next_s;
      if (out_free_s) begin
        if (skid_valid_r) begin
          out_valid_r <= 1'b1;
          out_data_r  <= skid_data_r;
          out_strb_r  <= skid_strb_r;
          out_user_r  <= skid_user_r;
          out_last_r  <= skid_last_r;
        end else if (accept_s) begin
          out_valid_r <= 1'b1;
          out_data_r  <= s_axis_tdata;
          out_strb_r  <= s_axis_tstrb;
          out_user_r  <= in_user_s;
          out_last_r  <= s_axis_tlast;
        end else begin
          out_valid_r <= 1'b0;
        end
      end else if (accept_s) begin
        skid_data_r <= s_axis_tdata;
        skid_strb_r <= s_axis_tstrb;
        skid_user_r <= in_user_s;
        skid_last_r <= s_axis_tlast;
      end
    end
  end

  assign s_axis_tready = tready_r;
  assign m_axis_tvalid = out_valid_r;
  assign m_axis_tdata  = out_data_r;
  assign m_axis_tstrb  = out_strb_r;
  assign m_axis_tuser  = out_user_r;
  assign m_axis_tlast  = out_last_r;
  assign ts_now        = ts_cnt_r;
  assign pkt_cnt       = pkt_cnt_r;

endmodule

// File: tb/tb_arrival_timestamper.sv
// Scoreboard bench for arrival_timestamper: the driver queues expected beats with
// hand-computed stamps, an independent monitor checks every egress handshake.
module tb_arrival_timestamper;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tstrb;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         stamp_en;
  logic         ts_clear;
  logic [31:0]  ts_now;
  logic [31:0]  pkt_cnt;

  int    total = 0;
  int    bad   = 0;
  beat_t exp_q[$];

  arrival_timestamper dut (
    .axi_aclk      (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .stamp_en      (stamp_en),
    .ts_clear      (ts_clear),
    .ts_now        (ts_now),
    .pkt_cnt       (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [7:0] id, input logic last);
    beat_t b;
    b.d = {32{id}};
    b.s = last ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    b.u = {16{id ^ 8'h5A}};
    b.l = last;
    return b;
  endfunction

  // Egress monitor: every handshake must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 256'(m_axis_tdata), 256'd0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("tdata", m_axis_tdata, e.d);
        check("tuser", 256'(m_axis_tuser), 256'(e.u));
        check("tstrb_tlast", 256'({m_axis_tstrb, m_axis_tlast}), 256'({e.s, e.l}));
      end
    end
  end

  // Present one beat, queue its expected egress once accepted; returns just after the accept edge
  task automatic send_beat(input beat_t b, input logic [31:0] stamp);
    beat_t e;
    bit    done;
    e = b;
    if (stamp_en) e.u[63:32] = stamp;
    s_axis_tdata  = b.d;
    s_axis_tstrb  = b.s;
    s_axis_tuser  = b.u;
    s_axis_tlast  = b.l;
    s_axis_tvalid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("accept_timeout", 256'd0, 256'd1);
  endtask

  task automatic drain();
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", 256'(exp_q.size()), 256'd0);
  endtask

  task automatic reset_dut();
    s_axis_tvalid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  // One-cycle clear; on return ts_now is 0
  task automatic clear_pulse();
    ts_clear = 1'b1;
    @(posedge clk); #1;
    ts_clear = 1'b0;
  endtask

  initial begin
    beat_t bp[4];
    beat_t b;
    int    idx;
    reset = 1'b1; ts_clear = 1'b0; stamp_en = 1'b1; m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tdata = 256'd0; s_axis_tstrb = 32'd0; s_axis_tuser = 128'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_m_tvalid", 256'(m_axis_tvalid), 256'd0);
    check("rst_s_tready", 256'(s_axis_tready), 256'd0);
    check("rst_ts_now", 256'(ts_now), 256'd0);
    check("rst_pkt_cnt", 256'(pkt_cnt), 256'd0);
    check("rst_m_tuser", 256'(m_axis_tuser), 256'd0);
    @(posedge clk); #1;
    check("post_rst_tready", 256'(s_axis_tready), 256'd1);
    check("post_rst_ts_now", 256'(ts_now), 256'd1);

    // 3-beat packet first accepted when the counter reads 10
    clear_pulse();
    check("clear_ts_now", 256'(ts_now), 256'd0);
    repeat (10) @(posedge clk);
    #1;
    check("ts_now_10", 256'(ts_now), 256'd10);
    check("idle_m_tvalid", 256'(m_axis_tvalid), 256'd0);
    send_beat(mk(8'h01, 1'b0), 32'd10);
    check("latency_m_tvalid", 256'(m_axis_tvalid), 256'd1);
    send_beat(mk(8'h02, 1'b0), 32'd10);
    send_beat(mk(8'h03, 1'b1), 32'd10);
    drain();

    // Back-to-back single-beat packets at counter 5,6,7
    reset_dut();
    clear_pulse();
    repeat (5) @(posedge clk);
    #1;
    send_beat(mk(8'h05, 1'b1), 32'd5);
    send_beat(mk(8'h06, 1'b1), 32'd6);
    send_beat(mk(8'h07, 1'b1), 32'd7);
    drain();
    @(posedge clk); #1;
    check("pkt_cnt_3", 256'(pkt_cnt), 256'd3);

    // Backpressure: 4-beat packet offered with egress stalled, stamp 3
    clear_pulse();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) bp[i] = mk(8'(8'h10 + i), (i == 3));
    m_axis_tready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 4) begin
        s_axis_tdata = bp[idx].d; s_axis_tstrb = bp[idx].s;
        s_axis_tuser = bp[idx].u; s_axis_tlast = bp[idx].l;
        s_axis_tvalid = 1'b1;
      end
      @(negedge clk);
      if (s_axis_tready && s_axis_tvalid) begin
        b = bp[idx];
        b.u[63:32] = 32'd3;
        exp_q.push_back(b);
        idx++;
      end
      @(posedge clk); #1;
    end
    check("bp_accepted", 256'(idx), 256'd2);
    check("bp_tready_low", 256'(s_axis_tready), 256'd0);
    check("bp_hold_valid", 256'(m_axis_tvalid), 256'd1);
    check("bp_hold_data", m_axis_tdata, bp[0].d);
    m_axis_tready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      s_axis_tdata = bp[idx].d; s_axis_tstrb = bp[idx].s;
      s_axis_tuser = bp[idx].u; s_axis_tlast = bp[idx].l;
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      if (s_axis_tready) begin
        b = bp[idx];
        b.u[63:32] = 32'd3;
        exp_q.push_back(b);
        idx++;
      end
      @(posedge clk); #1;
    end
    check("bp_all_accepted", 256'(idx), 256'd4);
    drain();

    // Stamp disabled: tuser passes untouched
    stamp_en = 1'b0;
    b = mk(8'h40, 1'b1);
    b.u = {4{32'hA5A5_A5A5}};
    send_beat(b, 32'd0);
    drain();
    stamp_en = 1'b1;

    // Clear coincident with an SOP accept at counter 100
    clear_pulse();
    repeat (100) @(posedge clk);
    #1;
    ts_clear = 1'b1;
    send_beat(mk(8'h30, 1'b1), 32'd100);
    ts_clear = 1'b0;
    check("clear_sop_ts_now", 256'(ts_now), 256'd0);
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    send_beat(mk(8'h31, 1'b1), 32'd1);
    drain();

    // Reset after beat 2 of a 4-beat packet; the tail becomes a new packet
    reset_dut();
    clear_pulse();
    repeat (2) @(posedge clk);
    #1;
    send_beat(mk(8'h20, 1'b0), 32'd2);
    send_beat(mk(8'h21, 1'b0), 32'd2);
    reset_dut();
    check("mid_rst_m_tvalid", 256'(m_axis_tvalid), 256'd0);
    check("mid_rst_m_tdata", m_axis_tdata, 256'd0);
    check("mid_rst_pkt_cnt", 256'(pkt_cnt), 256'd0);
    send_beat(mk(8'h22, 1'b0), 32'd1);
    send_beat(mk(8'h23, 1'b1), 32'd1);
    drain();
    @(posedge clk); #1;
    check("pkt_cnt_after_tail", 256'(pkt_cnt), 256'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
